// File: rtl/vga_blit_dma.sv
// ---------------------------------------------------------------------------
// vga_blit_dma
//   Blitter DMA for the gfx card. Copies a (WIDTH+1) x (HEIGHT+1) rectangle
//   from tiled source RAM into the framebuffer column by column, or fills the
//   rectangle with a constant colour. The CPU programs it through a 16-entry
//   register window; the video bus is shared with scan-out and is only used
//   in cycles where i_free_vbus_b is low.
//
//   Optional feature: define VGA_BLIT_FLIP_EN to honour CTRL bits 3/4
//   (mirror destination x / y). Without the macro those bits are ignored.
//
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_reg_we/addr/data  CPU register write port
//   o_reg_rdata      status: bit0 active, bit1 done (sticky)
//   o_src_re/addr/page  source read request, data back on i_src_data next cycle
//   i_free_vbus_b    low = video bus available this cycle
//   o_dst_we/addr/data  framebuffer write
//   o_active         transfer in progress
//   o_done           one-cycle pulse on completion or abort
// ---------------------------------------------------------------------------
module vga_blit_dma #(
  parameter int SRC_XW = 8,
  parameter int SRC_YW = 5,
  parameter int PAGE_W = 2,
  parameter int DST_XW = 8,
  parameter int DST_YW = 8,
  parameter int DW     = 8,
  parameter int CNT_W  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reg_we,
  input  logic [3:0]                 i_reg_addr,
  input  logic [DW-1:0]              i_reg_data,
  output logic [DW-1:0]              o_reg_rdata,
  output logic                       o_src_re,
  output logic [SRC_YW+SRC_XW-1:0]   o_src_addr,
  output logic [PAGE_W-1:0]          o_src_page,
  input  logic [DW-1:0]              i_src_data,
  input  logic                       i_free_vbus_b,
  output logic                       o_dst_we,
  output logic [DST_YW+DST_XW-1:0]   o_dst_addr,
  output logic [DW-1:0]              o_dst_data,
  output logic                       o_active,
  output logic                       o_done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t state_q, state_d;

  // programming registers
  logic [SRC_XW-1:0] src_x_q;
  logic [SRC_YW-1:0] src_y_q;
  logic [PAGE_W-1:0] page_q;
  logic [DST_XW-1:0] dst_x_q;
  logic [DST_YW-1:0] dst_y_q;
  logic [CNT_W-1:0]  width_q, height_q;
  logic [7:0]        mask_q;
  logic [DW-1:0]     key_q, fill_q;
  logic              copy_all_q, fill_mode_q;
`ifdef VGA_BLIT_FLIP_EN
  logic              flip_x_q, flip_y_q;
`endif

  // traversal state
  logic [CNT_W-1:0]  x_q, y_q;
  logic [SRC_YW-1:0] row_q;
  logic [SRC_XW-1:0] col_q;

  // pipeline
  logic                     vld_p1_q, rd_p1_q;
  logic [DST_YW+DST_XW-1:0] addr_p1_q;
  logic [DW-1:0]            skid_p1_q;

  logic done_q, done_d, done_flag_q;

  logic ctrl_wr, active, start, abort, go, issue, last_pix, finish;
  logic [SRC_XW-1:0] xmask;
  logic [SRC_YW-1:0] ymask;
  logic [DST_XW-1:0] dx;
  logic [DST_YW-1:0] dy;
  logic [DW-1:0]     pix;
  logic              skip, wr_copy, wr_fill;

  // Masked increment: only the bits under the mask count, the rest stay put,
  // so the walk wraps inside an aligned 2^k tile.
  function automatic logic [SRC_XW-1:0] tile_inc_x(input logic [SRC_XW-1:0] v,
                                                   input logic [SRC_XW-1:0] m);
    return (v & ~m) | ((v + SRC_XW'(1)) & m);
  endfunction

  function automatic logic [SRC_YW-1:0] tile_inc_y(input logic [SRC_YW-1:0] v,
                                                   input logic [SRC_YW-1:0] m);
    return (v & ~m) | ((v + SRC_YW'(1)) & m);
  endfunction

  assign ctrl_wr  = i_reg_we && (i_reg_addr == 4'd7);
  assign active   = (state_q != S_IDLE);
  assign start    = ctrl_wr && !i_reg_data[2] && !active;
  assign abort    = ctrl_wr && i_reg_data[2] && active;
  // an abort cycle issues nothing and drops the pending write
  assign go       = !i_free_vbus_b && !abort;
  assign issue    = (state_q == S_RUN) && go;
  assign last_pix = (x_q == width_q) && (y_q == height_q);
  assign xmask    = SRC_XW'(mask_q[4:0]);
  assign ymask    = SRC_YW'(mask_q[7:5]);

  always_comb begin
    dx = dst_x_q + DST_XW'(x_q);
    dy = dst_y_q + DST_YW'(y_q);
`ifdef VGA_BLIT_FLIP_EN
    if (flip_x_q) dx = dst_x_q - DST_XW'(x_q);
    if (flip_y_q) dy = dst_y_q - DST_YW'(y_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)                  state_d = S_IDLE;
        else if (issue && last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort) state_d = S_IDLE;
        else if (!vld_p1_q || go) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_d = abort || finish;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      done_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start)       done_flag_q <= 1'b0;
      else if (done_d) done_flag_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_x_q     <= '0;
      src_y_q     <= '0;
      page_q      <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      width_q     <= '0;
      height_q    <= '0;
      mask_q      <= 8'hFF;
      key_q       <= '0;
      fill_q      <= '0;
      copy_all_q  <= 1'b0;
      fill_mode_q <= 1'b0;
`ifdef VGA_BLIT_FLIP_EN
      flip_x_q    <= 1'b0;
      flip_y_q    <= 1'b0;
`endif
    end else if (i_reg_we && !active) begin
      case (i_reg_addr)
        4'd0: src_x_q  <= SRC_XW'(i_reg_data);
        4'd1: begin
          src_y_q <= i_reg_data[SRC_YW-1:0];
          page_q  <= i_reg_data[SRC_YW+PAGE_W-1:SRC_YW];
        end
        4'd2: dst_x_q  <= DST_XW'(i_reg_data);
        4'd3: dst_y_q  <= DST_YW'(i_reg_data);
        4'd4: width_q  <= CNT_W'(i_reg_data);
        4'd5: height_q <= CNT_W'(i_reg_data);
        4'd6: mask_q   <= 8'(i_reg_data);
        4'd7: begin
          if (!i_reg_data[2]) begin
            copy_all_q  <= i_reg_data[0];
            fill_mode_q <= i_reg_data[1];
`ifdef VGA_BLIT_FLIP_EN
            flip_x_q    <= i_reg_data[3];
            flip_y_q    <= i_reg_data[4];
`endif
          end
        end
        4'd8: key_q  <= i_reg_data;
        4'd9: fill_q <= i_reg_data;
        default: ;
      endcase
    end
  end

  // ---- stage 1: issue source read / fill write, advance traversal ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q   <= '0;
      y_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (start) begin
      x_q   <= '0;
      y_q   <= '0;
      row_q <= src_y_q;
      col_q <= src_x_q;
    end else if (issue) begin
      if (y_q == height_q) begin
        y_q   <= '0;
        x_q   <= x_q + CNT_W'(1);
        row_q <= src_y_q;
        col_q <= tile_inc_x(col_q, xmask);
      end else begin
        y_q   <= y_q + CNT_W'(1);
        row_q <= tile_inc_y(row_q, ymask);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1_q <= 1'b0;
      rd_p1_q  <= 1'b0;
    end else begin
      rd_p1_q <= o_src_re;
      if (abort)              vld_p1_q <= 1'b0;
      else if (!i_free_vbus_b) vld_p1_q <= o_src_re;
    end
  end

  // ---- stage 2: framebuffer write; skid holds read data across stalls ----
  always_ff @(posedge i_clk) begin
    if (rd_p1_q) skid_p1_q <= i_src_data;
    if (issue)   addr_p1_q <= {dy, dx};
  end

  assign pix     = rd_p1_q ? i_src_data : skid_p1_q;
  assign skip    = !copy_all_q && (pix == key_q);
  assign wr_copy = vld_p1_q && go && !skip;
  assign wr_fill = issue && fill_mode_q;

  assign o_src_re    = issue && !fill_mode_q;
  assign o_src_addr  = o_src_re ? {row_q, col_q} : '0;
  assign o_src_page  = o_src_re ? page_q : '0;
  assign o_dst_we    = wr_copy || wr_fill;
  assign o_dst_addr  = wr_fill ? {dy, dx} : (wr_copy ? addr_p1_q : '0);
  assign o_dst_data  = wr_fill ? fill_q : (wr_copy ? pix : '0);
  assign o_active    = active;
  assign o_done      = done_q;
  assign o_reg_rdata = DW'({done_flag_q, active});

endmodule

// File: tb/tb_vga_blit_dma.sv
module tb_vga_blit_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_we = 1'b0;
  logic [3:0]  reg_addr = '0;
  logic [7:0]  reg_data = '0;
  logic [7:0]  reg_rdata;
  logic        src_re;
  logic [12:0] src_addr;
  logic [1:0]  src_page;
  logic [7:0]  src_data = '0;
  logic        bus_b = 1'b0;
  logic        dst_we;
  logic [15:0] dst_addr;
  logic [7:0]  dst_data;
  logic        active, done;

  vga_blit_dma dut (
    .i_clk(clk), .i_rst(rst),
    .i_reg_we(reg_we), .i_reg_addr(reg_addr), .i_reg_data(reg_data),
    .o_reg_rdata(reg_rdata),
    .o_src_re(src_re), .o_src_addr(src_addr), .o_src_page(src_page),
    .i_src_data(src_data), .i_free_vbus_b(bus_b),
    .o_dst_we(dst_we), .o_dst_addr(dst_addr), .o_dst_data(dst_data),
    .o_active(active), .o_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // source RAM model: mode 0 returns the address low byte, mode 1 a small table
  int mode = 0;
  function automatic logic [7:0] src_model(input int m, input logic [12:0] a);
    if (m == 0) return a[7:0];
    case (a)
      13'h000: return 8'h00;
      13'h100: return 8'h05;
      13'h001: return 8'h00;
      13'h101: return 8'h07;
      default: return 8'hEE;
    endcase
  endfunction

  always @(posedge clk) if (src_re) src_data <= src_model(mode, src_addr);

  // bus monitor
  logic [7:0]  re_col_q[$];
  int          re_cyc_q[$];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  int          busy_wr = 0;

  always @(negedge clk) begin
    if (src_re) begin re_col_q.push_back(src_addr[7:0]); re_cyc_q.push_back(cyc); end
    if (dst_we) begin
      wr_addr_q.push_back(dst_addr); wr_data_q.push_back(dst_data); wr_cyc_q.push_back(cyc);
      if (bus_b) busy_wr++;
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  int wr_edge = 0;
  task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    reg_we = 1'b1; reg_addr = a; reg_data = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
    wr_edge = cyc;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_cyc_q.size() == base && n < 300) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, done_cyc_q.size() - base, 1);
  endtask

  localparam logic [15:0] T1_A [4] = '{16'h2010, 16'h2110, 16'h2011, 16'h2111};
  localparam logic [7:0]  T1_D [4] = '{8'h00, 8'h00, 8'h01, 8'h01};
  localparam logic [7:0]  T5_C [6] = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03};
  localparam logic [1:0]  STALL [5] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0};

  int br, bw, bd, t0;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_src_re", src_re, 0);
    chk("rst_dst_we", dst_we, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", reg_rdata, 0);
    chk("rst_dst_addr", dst_addr, 0);
    @(negedge clk) rst = 1'b0;

    // 1: 2x2 copy-all
    reg_wr(2, 8'h10); reg_wr(3, 8'h20); reg_wr(4, 8'd1); reg_wr(5, 8'd1);
    br = re_cyc_q.size(); bw = wr_cyc_q.size(); bd = done_cyc_q.size();
    reg_wr(7, 8'h01);
    t0 = wr_edge;
    chk("t1_active", active, 1);
    chk("t1_rdata_busy", reg_rdata, 8'h01);
    wait_done(bd, "t1_done_cnt");
    chk("t1_re_cnt", re_cyc_q.size() - br, 4);
    chk("t1_wr_cnt", wr_cyc_q.size() - bw, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), wr_addr_q[bw+i], T1_A[i]);
      chk($sformatf("t1_data%0d", i), wr_data_q[bw+i], T1_D[i]);
    end
    chk("t1_first_re_lat", re_cyc_q[br] - t0, 0);
    chk("t1_first_wr_lat", wr_cyc_q[bw] - t0, 1);
    chk("t1_done_lat", done_cyc_q[bd] - re_cyc_q[br+3], 2);
    chk("t1_rdata_done", reg_rdata, 8'h02);

    // 2: key skip
    mode = 1;
    reg_wr(8, 8'h00);
    bw = wr_cyc_q.size(); bd = done_cyc_q.size();
    reg_wr(7, 8'h00);
    wait_done(bd, "t2_done_cnt");
    chk("t2_wr_cnt", wr_cyc_q.size() - bw, 2);
    chk("t2_addr0", wr_addr_q[bw], 16'h2110);
    chk("t2_data0", wr_data_q[bw], 8'h05);
    chk("t2_addr1", wr_addr_q[bw+1], 16'h2111);
    chk("t2_data1", wr_data_q[bw+1], 8'h07);
    mode = 0;

    // 3: fill
    reg_wr(9, 8'hAA); reg_wr(4, 8'd3); reg_wr(5, 8'd0);
    br = re_cyc_q.size(); bw = wr_cyc_q.size(); bd = done_cyc_q.size();
    reg_wr(7, 8'h02);
    t0 = wr_edge;
    wait_done(bd, "t3_done_cnt");
    chk("t3_re_cnt", re_cyc_q.size() - br, 0);
    chk("t3_wr_cnt", wr_cyc_q.size() - bw, 4);
    chk("t3_first_wr_lat", wr_cyc_q[bw] - t0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_addr%0d", i), wr_addr_q[bw+i], 16'h2010 + 16'(i));
      chk($sformatf("t3_data%0d", i), wr_data_q[bw+i], 8'hAA);
    end

    // 4: stalled copy must match the unstalled one
    reg_wr(4, 8'd1); reg_wr(5, 8'd1);
    bw = wr_cyc_q.size(); bd = done_cyc_q.size();
    reg_wr(7, 8'h01);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; bus_b = STALL[i][0];
    end
    @(posedge clk); #1; bus_b = 1'b0;
    wait_done(bd, "t4_done_cnt");
    chk("t4_busy_wr", busy_wr, 0);
    chk("t4_wr_cnt", wr_cyc_q.size() - bw, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_addr%0d", i), wr_addr_q[bw+i], T1_A[i]);
      chk($sformatf("t4_data%0d", i), wr_data_q[bw+i], T1_D[i]);
    end

    // 5: x tiling mask
    reg_wr(6, 8'hE3); reg_wr(0, 8'h02); reg_wr(4, 8'd5); reg_wr(5, 8'd0);
    br = re_cyc_q.size(); bd = done_cyc_q.size();
    reg_wr(7, 8'h01);
    wait_done(bd, "t5_done_cnt");
    chk("t5_re_cnt", re_cyc_q.size() - br, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t5_col%0d", i), re_col_q[br+i], T5_C[i]);

    // 6: abort after 3 pixels
    reg_wr(0, 8'h00); reg_wr(4, 8'd3); reg_wr(5, 8'd3);
    br = re_cyc_q.size(); bw = wr_cyc_q.size(); bd = done_cyc_q.size();
    reg_wr(7, 8'h01);
    repeat (2) @(posedge clk);
    reg_wr(7, 8'h04);
    chk("t6_active", active, 0);
    chk("t6_done_pulse", done, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_re_cnt", re_cyc_q.size() - br, 3);
    chk("t6_wr_cnt", wr_cyc_q.size() - bw, 2);
    chk("t6_done_cnt", done_cyc_q.size() - bd, 1);
    chk("t6_done_cyc", done_cyc_q[bd], wr_edge);
    chk("t6_rdata", reg_rdata, 8'h02);

    // 7: reset after 3 pixels
    br = re_cyc_q.size(); bw = wr_cyc_q.size(); bd = done_cyc_q.size();
    reg_wr(7, 8'h01);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t7_src_re", src_re, 0);
    chk("t7_dst_we", dst_we, 0);
    chk("t7_active", active, 0);
    chk("t7_src_addr", src_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t7_re_cnt", re_cyc_q.size() - br, 3);
    chk("t7_wr_cnt", wr_cyc_q.size() - bw, 2);
    chk("t7_done_cnt", done_cyc_q.size() - bd, 0);
    chk("t7_rdata", reg_rdata, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
